// File: rtl/pipelined_cla_addsub.sv
// Pipelined add/subtract: one SEG-bit carry-lookahead segment per stage, carry registered between stages.
// Supports ADD/SUB/ADC/SBB with cout, overflow, zero and negative flags under valid/ready flow control.
module pipelined_cla_addsub #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_add1,
   input  logic [WIDTH-1:0] i_add2,
   input  logic [1:0]       i_op,
   input  logic             i_carry,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   output logic             o_cout,
   output logic             o_overflow,
   output logic             o_zero,
   output logic             o_neg
);
   localparam int NSTG = WIDTH / SEG;

   typedef struct packed {
      logic [SEG-1:0] sum;
      logic           cout;
      logic           cmsb;
   } seg_t;

   function automatic seg_t cla_seg(input logic [SEG-1:0] a, input logic [SEG-1:0] b,
                                    input logic cin);
      logic [SEG:0] c;
      seg_t r;
      c[0] = cin;
      for (int unsigned i = 0; i < SEG; i++)
         c[i+1] = (a[i] & b[i]) | ((a[i] | b[i]) & c[i]);
      r.sum  = a ^ b ^ c[SEG-1:0];
      r.cout = c[SEG];
      r.cmsb = c[SEG-1];
      return r;
   endfunction

   logic                 adv;
   logic [NSTG-1:0]      vld;
   // data_q[k]: segments 0..k hold results, the rest still hold raw A
   logic [WIDTH-1:0]     data_q [NSTG];
   logic [WIDTH-1:0]     b_q    [NSTG];
   logic                 cy_q   [NSTG];
   logic                 cm_q   [NSTG];
   logic [NSTG-1:0]      zb_q   [NSTG];

   // Index k is the input of stage k; index NSTG is the output of the last stage.
   logic [WIDTH-1:0]     in_data [NSTG+1];
   logic [WIDTH-1:0]     in_b    [NSTG+1];
   logic                 in_cy   [NSTG+1];
   logic [NSTG-1:0]      in_zb   [NSTG+1];

   seg_t                 sg      [NSTG];
   logic [WIDTH-1:0]     data_n  [NSTG];
   logic [WIDTH-1:0]     b_n     [NSTG];
   logic                 cy_n    [NSTG];
   logic                 cm_n    [NSTG];
   logic [NSTG-1:0]      zb_n    [NSTG];

   always_comb begin
      adv        = !vld[NSTG-1] | i_ready;
      in_data[0] = i_add1;
      in_b[0]    = i_op[0] ? ~i_add2 : i_add2;
      in_cy[0]   = i_op[1] ? i_carry : i_op[0];
      in_zb[0]   = '0;
      for (int unsigned k = 1; k <= NSTG; k++) begin
         in_data[k] = data_q[k-1];
         in_b[k]    = b_q[k-1];
         in_cy[k]   = cy_q[k-1];
         in_zb[k]   = zb_q[k-1];
      end
      for (int unsigned k = 0; k < NSTG; k++) begin
         sg[k]     = cla_seg(in_data[k][k*SEG +: SEG], in_b[k][k*SEG +: SEG], in_cy[k]);
         data_n[k] = in_data[k];
         data_n[k][k*SEG +: SEG] = sg[k].sum;
         b_n[k]    = in_b[k];
         cy_n[k]   = sg[k].cout;
         cm_n[k]   = sg[k].cmsb;
         zb_n[k]   = in_zb[k];
         zb_n[k][k] = ~|sg[k].sum;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld <= '0;
         for (int unsigned k = 0; k < NSTG; k++) begin
            data_q[k] <= '0;
            b_q[k]    <= '0;
            cy_q[k]   <= 1'b0;
            cm_q[k]   <= 1'b0;
            zb_q[k]   <= '0;
         end
      end else if (adv) begin
         vld[0] <= i_valid;
         for (int unsigned k = 1; k < NSTG; k++)
            vld[k] <= vld[k-1];
         for (int unsigned k = 0; k < NSTG; k++) begin
            data_q[k] <= data_n[k];
            b_q[k]    <= b_n[k];
            cy_q[k]   <= cy_n[k];
            cm_q[k]   <= cm_n[k];
            zb_q[k]   <= zb_n[k];
         end
      end
   end

   always_comb begin
      o_ready    = adv;
      o_valid    = vld[NSTG-1];
      o_result   = data_q[NSTG-1];
      o_cout     = cy_q[NSTG-1];
      o_overflow = cy_q[NSTG-1] ^ cm_q[NSTG-1];
      o_zero     = &zb_q[NSTG-1];
      o_neg      = data_q[NSTG-1][WIDTH-1];
   end
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed vectors and handshake sequences on 32/8,
// plus randomized traffic on 32/8, 16/16 and 24/8 checked against an arithmetic model.
module tb_pipelined_cla_addsub;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vin = 1'b0;
   logic        rdy = 1'b1;
   logic        cin = 1'b0;
   logic [1:0]  op  = 2'b00;
   logic [31:0] a   = '0;
   logic [31:0] b   = '0;

   logic [2:0]  ordy, ovld, ocout, oovf, ozero, oneg;
   logic [31:0] r0;
   logic [15:0] r1;
   logic [23:0] r2;

   always #5 clk = ~clk;

   pipelined_cla_addsub #(.WIDTH(32), .SEG(8)) u32 (
      .i_clk(clk), .i_rst(rst), .i_valid(vin), .o_ready(ordy[0]),
      .i_add1(a), .i_add2(b), .i_op(op), .i_carry(cin),
      .o_valid(ovld[0]), .i_ready(rdy), .o_result(r0), .o_cout(ocout[0]),
      .o_overflow(oovf[0]), .o_zero(ozero[0]), .o_neg(oneg[0]));

   pipelined_cla_addsub #(.WIDTH(16), .SEG(16)) u16 (
      .i_clk(clk), .i_rst(rst), .i_valid(vin), .o_ready(ordy[1]),
      .i_add1(a[15:0]), .i_add2(b[15:0]), .i_op(op), .i_carry(cin),
      .o_valid(ovld[1]), .i_ready(rdy), .o_result(r1), .o_cout(ocout[1]),
      .o_overflow(oovf[1]), .o_zero(ozero[1]), .o_neg(oneg[1]));

   pipelined_cla_addsub #(.WIDTH(24), .SEG(8)) u24 (
      .i_clk(clk), .i_rst(rst), .i_valid(vin), .o_ready(ordy[2]),
      .i_add1(a[23:0]), .i_add2(b[23:0]), .i_op(op), .i_carry(cin),
      .o_valid(ovld[2]), .i_ready(rdy), .o_result(r2), .o_cout(ocout[2]),
      .o_overflow(oovf[2]), .o_zero(ozero[2]), .o_neg(oneg[2]));

   typedef struct {
      logic [31:0] res;
      logic        cout;
      logic        ovf;
      logic        zero;
      logic        neg;
   } res_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      res_t        exp;
   } vec_t;

   res_t        q [3][$];
   int          checks = 0;
   int          errors = 0;
   int          acc32  = 0;
   int          widths [3] = '{32, 16, 24};
   bit   [2:0]  stalled = '0;
   logic [31:0] snap_res [3];
   logic [3:0]  snap_f   [3];
   vec_t        tv [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: plain (W+1)-bit arithmetic; overflow from operand/result signs.
   function automatic res_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                  input logic [1:0] o, input logic c);
      logic [63:0] mask, xm, yp, s;
      res_t r;
      mask   = (64'd1 << w) - 64'd1;
      xm     = {32'b0, x} & mask;
      yp     = (o[0] ? ~{32'b0, y} : {32'b0, y}) & mask;
      s      = xm + yp + {63'b0, (o[1] ? c : o[0])};
      r.res  = s[31:0] & mask[31:0];
      r.cout = s[w];
      r.neg  = s[w-1];
      r.ovf  = (xm[w-1] == yp[w-1]) && (s[w-1] != xm[w-1]);
      r.zero = (r.res == 32'b0);
      return r;
   endfunction

   function automatic vec_t mkvec(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic c, input logic [31:0] res, input logic co,
                                  input logic ov, input logic z, input logic n);
      vec_t v;
      v.op = o; v.a = x; v.b = y; v.cin = c;
      v.exp.res = res; v.exp.cout = co; v.exp.ovf = ov; v.exp.zero = z; v.exp.neg = n;
      return v;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 9))
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return 32'h0000_FFFF;
         5: return 32'h0080_0000;
         6: return 32'h00FF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   task automatic mon(input int d, input logic v, input logic ro, input logic [31:0] res,
                      input logic co, input logic ov, input logic z, input logic n);
      res_t e;
      if (stalled[d]) begin
         chk($sformatf("d%0d_hold_valid", d), {31'b0, v}, 32'd1);
         chk($sformatf("d%0d_hold_res", d), res, snap_res[d]);
         chk($sformatf("d%0d_hold_flags", d), {28'b0, co, ov, z, n}, {28'b0, snap_f[d]});
      end
      if (v && !rdy) chk($sformatf("d%0d_stall_ready", d), {31'b0, ro}, 32'd0);
      if (!v)        chk($sformatf("d%0d_idle_ready", d), {31'b0, ro}, 32'd1);
      if (v && rdy) begin
         if (q[d].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL d%0d_spurious: o_valid=1 with result %h, required no pending result", d, res);
         end else begin
            e = q[d].pop_front();
            chk($sformatf("d%0d_res", d), res, e.res);
            chk($sformatf("d%0d_cout", d), {31'b0, co}, {31'b0, e.cout});
            chk($sformatf("d%0d_ovf", d), {31'b0, ov}, {31'b0, e.ovf});
            chk($sformatf("d%0d_zero", d), {31'b0, z}, {31'b0, e.zero});
            chk($sformatf("d%0d_neg", d), {31'b0, n}, {31'b0, e.neg});
         end
      end
      stalled[d]  = v && !rdy;
      snap_res[d] = res;
      snap_f[d]   = {co, ov, z, n};
      if (vin && ro) begin
         q[d].push_back(model(widths[d], a, b, op, cin));
         if (d == 0) acc32++;
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         for (int d = 0; d < 3; d++) q[d].delete();
         stalled = '0;
      end else begin
         mon(0, ovld[0], ordy[0], r0, ocout[0], oovf[0], ozero[0], oneg[0]);
         mon(1, ovld[1], ordy[1], {16'b0, r1}, ocout[1], oovf[1], ozero[1], oneg[1]);
         mon(2, ovld[2], ordy[2], {8'b0, r2}, ocout[2], oovf[2], ozero[2], oneg[2]);
      end
   end

   task automatic run_vec(input vec_t v);
      int n;
      @(posedge clk); #1;
      vin = 1'b1; op = v.op; a = v.a; b = v.b; cin = v.cin;
      @(posedge clk); #1;
      vin = 1'b0;
      n = 1;
      while (!ovld[0] && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ovld[0]) begin
         checks++;
         errors++;
         $display("FAIL vec_timeout: o_valid=0 after %0d cycles, required 1 after 4", n);
      end else begin
         chk("vec_latency", n, 32'd4);
         chk("vec_res", r0, v.exp.res);
         chk("vec_cout", {31'b0, ocout[0]}, {31'b0, v.exp.cout});
         chk("vec_ovf", {31'b0, oovf[0]}, {31'b0, v.exp.ovf});
         chk("vec_zero", {31'b0, ozero[0]}, {31'b0, v.exp.zero});
         chk("vec_neg", {31'b0, oneg[0]}, {31'b0, v.exp.neg});
      end
   endtask

   task automatic issue(input int cnt);
      for (int i = 0; i < cnt; i++) begin
         vin = 1'b1; a = pick(); b = pick(); op = 2'($urandom_range(0, 3)); cin = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      vin = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt, first, last, start, cyc;
      logic [31:0] snap;

      tv[0] = mkvec(2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      tv[1] = mkvec(2'b01, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
      tv[2] = mkvec(2'b01, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
      tv[3] = mkvec(2'b10, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0);
      tv[4] = mkvec(2'b11, 32'h0000_000A, 32'h0000_0003, 1'b0, 32'h0000_0006, 1'b1, 1'b0, 1'b0, 1'b0);
      tv[5] = mkvec(2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
      tv[6] = mkvec(2'b01, 32'h0000_0003, 32'h0000_0003, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
      tv[7] = mkvec(2'b10, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, ovld[0]}, 32'd0);
      chk("rst_res", r0, 32'd0);
      chk("rst_cout", {31'b0, ocout[0]}, 32'd0);
      chk("rst_ovf", {31'b0, oovf[0]}, 32'd0);
      chk("rst_zero", {31'b0, ozero[0]}, 32'd0);
      chk("rst_neg", {31'b0, oneg[0]}, 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_ready", {29'b0, ordy}, 32'd7);

      for (int i = 0; i < 8; i++) run_vec(tv[i]);

      // back-to-back, then stall
      @(posedge clk); #1;
      issue(4);
      cnt = 0; first = -1; last = -1;
      for (int n = 0; n < 12; n++) begin
         if (ovld[0]) begin
            cnt++;
            if (first < 0) first = n;
            last = n;
         end
         @(posedge clk); #1;
      end
      chk("b2b_count", cnt, 32'd4);
      chk("b2b_span", last - first, 32'd3);

      issue(4);
      chk("stall_pre_valid", {31'b0, ovld[0]}, 32'd1);
      snap = r0;
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("stall_ready", {31'b0, ordy[0]}, 32'd0);
         chk("stall_valid", {31'b0, ovld[0]}, 32'd1);
         chk("stall_res", r0, snap);
      end
      rdy = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk("stall_drained", q[0].size(), 32'd0);

      // reset with ops in flight, and a valid op presented during reset
      issue(3);
      rst = 1'b1; vin = 1'b1; a = 32'h1234_5678; b = 32'h1111_1111; op = 2'b00;
      @(posedge clk); #1;
      rst = 1'b0; vin = 1'b0;
      chk("flush_valid", {31'b0, ovld[0]}, 32'd0);
      chk("flush_ready", {31'b0, ordy[0]}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("flush_no_stale", {29'b0, ovld}, 32'd0);
      end
      run_vec(tv[3]);

      // random traffic across all three configurations
      start = acc32;
      cyc   = 0;
      while (acc32 - start < 10000 && cyc < 40000) begin
         vin = ($urandom_range(0, 9) < 7);
         rdy = ($urandom_range(0, 9) < 8);
         a = pick(); b = pick();
         op = 2'($urandom_range(0, 3));
         cin = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         cyc++;
      end
      if (acc32 - start < 10000) begin
         checks++;
         errors++;
         $display("FAIL rand_budget: accepted %0d ops, required 10000", acc32 - start);
      end
      vin = 1'b0; rdy = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) chk($sformatf("d%0d_drain", d), q[d].size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
